// File: rtl/uart_tx_framer.sv
// UART transmit framer.
// Takes one word per valid/ready handshake and shifts it out as a frame:
// start bit, data bits LSB first, an optional parity bit, then one or two
// stop bits. Each bit is advanced by a single-cycle baud_tick from an
// external baud generator. enable_baud is held high for the whole frame.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line high, tx_ready high, waiting for tx_valid
// SYNC   | word latched, waiting for the first tick to align the start bit
// START  | driving the start bit (0)
// DATA   | driving data bits LSB first, folding each one into parity
// PARITY | driving the parity bit (only when PARITY_EN)
// STOP   | driving stop bit(s) (1), counting STOP_BITS ticks
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 enable_baud,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // One extra counter bit so the count reaches DATA_BITS without wrapping.
    localparam int               CNT_W     = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 parity_acc;
    logic                 stop_cnt;

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            parity_acc  <= 1'b0;
            stop_cnt    <= 1'b0;
            tx_serial   <= 1'b1;
            tx_ready    <= 1'b1;
            enable_baud <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        state       <= SYNC;
                        shift_reg   <= tx_data;
                        bit_cnt     <= '0;
                        parity_acc  <= 1'b0;
                        stop_cnt    <= 1'b0;
                        tx_ready    <= 1'b0;
                        tx_busy     <= 1'b1;
                        enable_baud <= 1'b1;
                    end
                end
                SYNC: begin
                    if (baud_tick) begin
                        state     <= START;
                        tx_serial <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state      <= DATA;
                        tx_serial  <= shift_reg[0];
                        parity_acc <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                        bit_cnt    <= CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN) begin
                                state     <= PARITY;
                                tx_serial <= parity_acc ^ PARITY_ODD;
                            end else begin
                                state     <= STOP;
                                tx_serial <= 1'b1;
                                stop_cnt  <= 1'b0;
                            end
                        end else begin
                            tx_serial  <= shift_reg[0];
                            parity_acc <= parity_acc ^ shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                            bit_cnt    <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        state     <= STOP;
                        tx_serial <= 1'b1;
                        stop_cnt  <= 1'b0;
                    end
                end
                STOP: begin
                    tx_serial <= 1'b1;
                    if (baud_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state       <= IDLE;
                            tx_done     <= 1'b1;
                            tx_ready    <= 1'b1;
                            tx_busy     <= 1'b0;
                            enable_baud <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four instances cover default framing,
// even parity, odd parity and two stop bits. Bits are sampled mid-period.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tick_cont = 1'b0;
    int         tcnt = 0;
    logic       scr_en = 1'b0;
    logic [7:0] scr_val = 8'h00;
    int         done_cnt0 = 0;

    logic       tx_valid    [4];
    logic [7:0] tx_data_r   [4];
    logic [7:0] tx_data     [4];
    logic       tx_ready    [4];
    logic       enable_baud [4];
    logic       tx_serial   [4];
    logic       tx_busy     [4];
    logic       tx_done     [4];

    int checks   = 0;
    int failures = 0;

    assign tx_data[0] = scr_en ? scr_val : tx_data_r[0];
    assign tx_data[1] = tx_data_r[1];
    assign tx_data[2] = tx_data_r[2];
    assign tx_data[3] = tx_data_r[3];

    uart_tx_framer u_dflt (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
        .enable_baud(enable_baud[0]), .tx_serial(tx_serial[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
    );

    uart_tx_framer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
        .enable_baud(enable_baud[1]), .tx_serial(tx_serial[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
    );

    uart_tx_framer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .tx_ready(tx_ready[2]),
        .enable_baud(enable_baud[2]), .tx_serial(tx_serial[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
    );

    uart_tx_framer #(.STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_valid(tx_valid[3]), .tx_data(tx_data[3]), .tx_ready(tx_ready[3]),
        .enable_baud(enable_baud[3]), .tx_serial(tx_serial[3]),
        .tx_busy(tx_busy[3]), .tx_done(tx_done[3])
    );

    always #5 clk = ~clk;

    // Free-running baud generator: one tick every 16 clocks, or always high.
    always @(posedge clk) begin
        #2;
        tcnt      = (tcnt == 15) ? 0 : tcnt + 1;
        baud_tick = tick_cont || (tcnt == 15);
        scr_val   = 8'($urandom);
    end

    // Count completion pulses of the default instance.
    always @(posedge clk) begin
        #1;
        if (tx_done[0] === 1'b1) done_cnt0++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word at a negedge, confirm acceptance on the next one.
    task automatic accept(input int idx, input logic [7:0] d, input string tag);
        tx_data_r[idx] = d;
        tx_valid[idx]  = 1'b1;
        @(negedge clk);
        chk({tag, "_acc_ready"}, 32'(tx_ready[idx]), 32'd0);
        chk({tag, "_acc_busy"}, 32'(tx_busy[idx]), 32'd1);
        chk({tag, "_acc_en"}, 32'(enable_baud[idx]), 32'd1);
        tx_valid[idx] = 1'b0;
    endtask

    // Wait for the start edge, check each bit mid-period, then the done cycle.
    // Returns in the tx_done cycle.
    task automatic frame(input int idx, input logic [11:0] exp, input int nbits, input string tag);
        for (int i = 0; i < 80; i++) begin
            if (tx_serial[idx] === 1'b0) break;
            @(negedge clk);
        end
        chk({tag, "_start_seen"}, 32'(tx_serial[idx]), 32'd0);
        for (int k = 0; k < nbits; k++) begin
            repeat ((k == 0) ? 8 : 16) @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, k), 32'(tx_serial[idx]), 32'(exp[k]));
            chk($sformatf("%s_ready%0d", tag, k), 32'(tx_ready[idx]), 32'd0);
        end
        repeat (8) @(negedge clk);
        chk({tag, "_done"}, 32'(tx_done[idx]), 32'd1);
        chk({tag, "_done_ready"}, 32'(tx_ready[idx]), 32'd1);
        chk({tag, "_done_busy"}, 32'(tx_busy[idx]), 32'd0);
        chk({tag, "_done_en"}, 32'(enable_baud[idx]), 32'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4; i++) begin
            tx_valid[i]  = 1'b0;
            tx_data_r[i] = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset state
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_serial%0d", i), 32'(tx_serial[i]), 32'd1);
            chk($sformatf("rst_ready%0d", i), 32'(tx_ready[i]), 32'd1);
            chk($sformatf("rst_en%0d", i), 32'(enable_baud[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(tx_busy[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(tx_done[i]), 32'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Default framing, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        accept(0, 8'hA5, "a5");
        frame(0, 12'b00_1101001010, 10, "a5");
        @(negedge clk);
        chk("a5_done_single", 32'(tx_done[0]), 32'd0);

        // Parity variants
        accept(1, 8'hA5, "even_a5");
        frame(1, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, "even_a5");
        @(negedge clk);
        accept(1, 8'h07, "even_07");
        frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, "even_07");
        @(negedge clk);
        accept(2, 8'h07, "odd_07");
        frame(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, "odd_07");
        @(negedge clk);

        // Two stop bits, next word held valid and taken in the done cycle
        accept(3, 8'h00, "s2_00");
        tx_data_r[3] = 8'h3C;
        tx_valid[3]  = 1'b1;
        frame(3, {2'b11, 8'h00, 1'b0}, 11, "s2_00");
        @(negedge clk);
        chk("s2_b2b_ready", 32'(tx_ready[3]), 32'd0);
        chk("s2_b2b_done", 32'(tx_done[3]), 32'd0);
        chk("s2_b2b_busy", 32'(tx_busy[3]), 32'd1);
        tx_valid[3] = 1'b0;
        frame(3, {2'b11, 8'h3C, 1'b0}, 11, "s2_3c");
        @(negedge clk);

        // Valid held with data changing every cycle during the frame
        tx_data_r[0] = 8'h5A;
        tx_valid[0]  = 1'b1;
        @(negedge clk);
        chk("scr_acc_ready", 32'(tx_ready[0]), 32'd0);
        scr_en = 1'b1;
        frame(0, {2'b01, 8'h5A, 1'b0}, 10, "scr_5a");
        scr_en       = 1'b0;
        tx_data_r[0] = 8'hC3;
        @(negedge clk);
        chk("scr_next_acc", 32'(tx_ready[0]), 32'd0);
        chk("scr_next_done", 32'(tx_done[0]), 32'd0);
        tx_valid[0] = 1'b0;
        frame(0, {2'b01, 8'hC3, 1'b0}, 10, "scr_c3");
        @(negedge clk);

        // Reset in the middle of DATA
        accept(0, 8'h00, "rst_mid");
        for (int i = 0; i < 80; i++) begin
            if (tx_serial[0] === 1'b0) break;
            @(negedge clk);
        end
        repeat (24) @(negedge clk);
        chk("rst_mid_pre_serial", 32'(tx_serial[0]), 32'd0);
        d0  = done_cnt0;
        rst = 1'b1;
        #1;
        chk("rst_mid_serial", 32'(tx_serial[0]), 32'd1);
        chk("rst_mid_en", 32'(enable_baud[0]), 32'd0);
        chk("rst_mid_busy", 32'(tx_busy[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_mid_ready", 32'(tx_ready[0]), 32'd1);
        chk("rst_mid_no_done", 32'(done_cnt0), 32'(d0));
        accept(0, 8'h96, "post_rst");
        frame(0, {2'b01, 8'h96, 1'b0}, 10, "post_rst");
        @(negedge clk);

        // Acceptance coinciding with a tick: that tick is ignored
        for (int i = 0; i < 20; i++) begin
            if (tcnt == 15) break;
            @(negedge clk);
        end
        tx_data_r[0] = 8'h3A;
        tx_valid[0]  = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        chk("coin_acc_ready", 32'(tx_ready[0]), 32'd0);
        repeat (15) @(negedge clk);
        chk("coin_still_high", 32'(tx_serial[0]), 32'd1);
        frame(0, {2'b01, 8'h3A, 1'b0}, 10, "coin_3a");
        @(negedge clk);

        // baud_tick held high: one bit per clock, returns to idle
        tick_cont = 1'b1;
        repeat (3) @(negedge clk);
        tx_data_r[0] = 8'h0F;
        tx_valid[0]  = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        chk("cont_sync_serial", 32'(tx_serial[0]), 32'd1);
        chk("cont_sync_busy", 32'(tx_busy[0]), 32'd1);
        for (int k = 0; k < 10; k++) begin
            logic [9:0] cexp;
            cexp = {1'b1, 8'h0F, 1'b0};
            @(negedge clk);
            chk($sformatf("cont_bit%0d", k), 32'(tx_serial[0]), 32'(cexp[k]));
        end
        @(negedge clk);
        chk("cont_done", 32'(tx_done[0]), 32'd1);
        chk("cont_done_ready", 32'(tx_ready[0]), 32'd1);
        @(negedge clk);
        chk("cont_after_done", 32'(tx_done[0]), 32'd0);
        chk("cont_after_ready", 32'(tx_ready[0]), 32'd1);
        chk("cont_after_serial", 32'(tx_serial[0]), 32'd1);
        tick_cont = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- UART transmit framer: accepts one data word over a valid/ready handshake and serialises it as start bit, data bits (LSB first), optional parity bit, and stop bit(s).
- Each bit is advanced by a one-cycle baud_tick pulse supplied by the baud-rate generator.
- Asserts enable_baud toward that generator for the whole frame.
- Sits between the host-side byte interface and the TX pad.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal values 5..9.
- PARITY_EN, 0, 1 = insert parity bit after data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_tick  input  1  single-cycle pulse, one per bit period, from baud generator.
- tx_valid  input  1  host has a word to send.
- tx_data  input  DATA_BITS  word to send; sampled only at acceptance.
- tx_ready  output  1  framer can accept a word this cycle.
- enable_baud  output  1  request to baud generator to run.
- tx_serial  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when the last stop bit period ends.

Behaviour:
- Reset (asynchronous, immediate):
  - tx_serial=1, tx_ready=1, enable_baud=0, tx_busy=0, tx_done=0.
  - State=IDLE; shift register, bit counter and parity accumulator cleared.
- All outputs are registered. tx_ready=1 only in IDLE.
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE:
  - tx_serial=1; baud_tick ignored.
  - tx_valid & tx_ready at a clock edge = acceptance: latch tx_data, clear counters, go to SYNC.
  - tx_ready=0, tx_busy=1 and enable_baud=1 from the next cycle.
- SYNC: aligns to the free-running tick phase. tx_serial stays 1. On baud_tick go to START; tx_serial=0 from the following cycle.
- START: on baud_tick go to DATA; tx_serial=data[0].
- DATA:
  - On each baud_tick, shift right and output the next bit; fold each transmitted bit into parity.
  - After DATA_BITS bit periods, a tick moves to PARITY if PARITY_EN, else to STOP.
  - Bit counter width = clog2(DATA_BITS)+1; it must not wrap before reaching DATA_BITS.
- PARITY:
  - tx_serial = XOR of all data bits (even), or its inverse (PARITY_ODD=1).
  - On baud_tick go to STOP.
- STOP:
  - tx_serial=1; count baud_ticks.
  - On the STOP_BITS-th tick go to IDLE. tx_done=1 for exactly that next cycle; tx_ready=1, tx_busy=0, enable_baud=0 in the same cycle.
- Timing rules:
  - Each non-SYNC bit lasts exactly one tick-to-tick interval.
  - Latency from acceptance to the start-bit edge = the SYNC wait (up to one bit period) + 1 cycle.
- tx_valid while busy: ignored, no data corruption. tx_data changes after acceptance: no effect on the frame.
- Back-to-back frames:
  - A word presented during the tx_done cycle is accepted; tx_ready=1 in that cycle.
  - The next start bit follows the next SYNC tick, so the stop bit lasts at least one full bit period.
- baud_tick in the same cycle as acceptance: ignored (state is still IDLE).
- Reset mid-frame: line returns high immediately, no tx_done, frame discarded, tx_ready=1 after reset release.
- baud_tick held high continuously (misuse): advances one bit per clock. No lock-up is allowed.

Test Plan:
- Default params, baud_tick every 16 clk, send 0xA5 → after SYNC, tx_serial per bit period: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); one tx_done pulse; tx_ready low from acceptance+1 until tx_done.
- PARITY_EN=1 even, send 0xA5 → parity bit 0. Odd parity, send 0x07 → parity bit 0. Even parity, send 0x07 → parity bit 1. Frame length 11 bit periods.
- STOP_BITS=2, send 0x00 → start + eight 0s + two 1 bit periods; tx_done at the end of the second stop period; a new word held valid is accepted in the tx_done cycle.
- tx_valid held high with data changing every cycle during a frame → only the word present at acceptance is transmitted; subsequent words accepted only after tx_done.
- Assert rst mid-DATA → tx_serial=1 and enable_baud=0 asynchronously; no tx_done; the next frame after release is correct.
- Acceptance in the same cycle as a baud_tick → that tick is ignored; the start bit begins one cycle after the following tick, and its width = one full tick interval.
